// File: rtl/adler32_pkg.sv
// Shared constants and types for the parallel Adler-32 engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adler32_pkg;

  // Largest prime below 2^16; both Adler-32 sums are kept modulo this value.
  localparam int unsigned MOD_ADLER     = 65521;
  // Widest beat the per-beat sum datapath is sized for.
  localparam int unsigned DAT_BYTES_MAX = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/adler32_mod_red.sv
// Combinational reduction of a 32-bit unsigned value modulo 65521.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result follows the input.
module adler32_mod_red
  import adler32_pkg::*;
(
  input  logic [31:0] x_i,
  output logic [15:0] r_o
);

  // 2^16 == 15 (mod 65521): each fold replaces the upper half by 15x its value.
  // First fold leaves at most 20 bits, second fold at most 65760, so one
  // conditional subtraction finishes the job.
  logic [19:0] fold1;
  logic [16:0] fold2;

  // Two folds then a single conditional subtract.
  always_comb begin
    fold1 = 20'(x_i[15:0]) + 20'(x_i[31:16]) * 20'd15;
    fold2 = 17'(fold1[15:0]) + 17'(fold1[19:16]) * 17'd15;
    if (fold2 >= 17'(MOD_ADLER)) begin
      r_o = 16'(fold2 - 17'(MOD_ADLER));
    end else begin
      r_o = fold2[15:0];
    end
  end

endmodule

// File: rtl/adler32_par.sv
// Adler-32 over DAT_BYTES-wide beats, one beat per clock; optional seed preset via macro ADLER32_SEED_EN.
// Latency: 1 cycle from accepted beat to val_o/dat_o (done_o with the lst_i beat).
// Backpressure: rdy_o is high only while a stream is open; beats offered in IDLE are ignored.
module adler32_par
  import adler32_pkg::*;
#(
  parameter  int DAT_BYTES = 4,
  localparam int DAT_WD    = 8 * DAT_BYTES,
  localparam int NUM_WD    = $clog2(DAT_BYTES)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_i,
  input  logic              val_i,
  input  logic [DAT_WD-1:0] dat_i,
  input  logic [NUM_WD-1:0] num_i,
  input  logic              lst_i,
  output logic              rdy_o,
  output logic              done_o,
  output logic              val_o,
  output logic [31:0]       dat_o
`ifdef ADLER32_SEED_EN
  ,
  input  logic [31:0]       seed_i
`endif
);

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [31:0] dat_q, dat_d;
  logic        val_q, done_q;
  logic        accept;
  logic [15:0] seed_a, seed_b;
  logic [31:0] n_bytes, sum_a, sum_b, byte_v;
  logic [31:0] pre_a, pre_b;
  logic [15:0] a_red, b_red;

  // A start pulse always wins, so a beat in the same cycle is discarded.
  assign accept = val_i && rdy_o && !start_i;

`ifdef ADLER32_SEED_EN
  // Out-of-range seed halves are brought back into [0, 65520] by one subtraction.
  assign seed_a = (seed_i[15:0]  >= 16'(MOD_ADLER)) ? seed_i[15:0]  - 16'(MOD_ADLER) : seed_i[15:0];
  assign seed_b = (seed_i[31:16] >= 16'(MOD_ADLER)) ? seed_i[31:16] - 16'(MOD_ADLER) : seed_i[31:16];
`else
  assign seed_a = 16'd1;
  assign seed_b = 16'd0;
`endif

  // Per-beat sums: byte k (stream order) contributes once to A and (n-k) times to B.
  always_comb begin
    n_bytes = (num_i == '0) ? 32'(DAT_BYTES) : 32'(num_i);
    sum_a   = '0;
    sum_b   = '0;
    byte_v  = '0;
    for (int k = 0; k < DAT_BYTES; k++) begin
      byte_v = 32'(dat_i[DAT_WD-1-8*k -: 8]);
      if (32'(k) < n_bytes) begin
        sum_a = sum_a + byte_v;
        sum_b = sum_b + (n_bytes - 32'(k)) * byte_v;
      end
    end
    pre_a = 32'(a_q) + sum_a;
    pre_b = 32'(b_q) + n_bytes * 32'(a_q) + sum_b;
  end

  adler32_mod_red u_red_a (.x_i(pre_a), .r_o(a_red));
  adler32_mod_red u_red_b (.x_i(pre_b), .r_o(b_red));

  // Next-state for the stream FSM.
  always_comb begin
    state_d = state_q;
    if (start_i) begin
      state_d = ST_BUSY;
    end else if (accept && lst_i) begin
      state_d = ST_IDLE;
    end
  end

  // FSM output: beats are taken only while a stream is open.
  always_comb begin
    rdy_o = (state_q == ST_BUSY);
  end

  // Next values of the running sums and the published checksum.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    dat_d = dat_q;
    if (start_i) begin
      a_d = seed_a;
      b_d = seed_b;
    end else if (accept) begin
      a_d   = a_red;
      b_d   = b_red;
      dat_d = {b_red, a_red};
    end
  end

  // State, running sums and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      a_q     <= 16'd1;
      b_q     <= 16'd0;
      dat_q   <= '0;
      val_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dat_q   <= dat_d;
      val_q   <= accept;
      done_q  <= accept && lst_i;
    end
  end

  assign val_o  = val_q;
  assign done_o = done_q;
  assign dat_o  = dat_q;

endmodule

// File: tb/tb_adler32_par.sv
// Randomised and directed bench for adler32_par against a byte-serial Adler-32 model.
// Latency: checks outputs 1 cycle after each driven cycle.
// Backpressure: models rdy_o from stream open/close events.
module tb_adler32_par;

  localparam int DB = 4;
  localparam int MOD = 65521;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start_i, val_i, lst_i;
  logic [31:0] dat_i;
  logic [1:0]  num_i;
  logic        rdy_o, done_o, val_o;
  logic [31:0] dat_o;
`ifdef ADLER32_SEED_EN
  logic [31:0] seed_i;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference state: plain byte-at-a-time Adler-32.
  bit          m_busy;
  int unsigned m_a, m_b;
  logic [31:0] m_dat;

  adler32_par #(.DAT_BYTES(DB)) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .val_i(val_i), .dat_i(dat_i),
    .num_i(num_i), .lst_i(lst_i), .rdy_o(rdy_o), .done_o(done_o), .val_o(val_o),
    .dat_o(dat_o)
`ifdef ADLER32_SEED_EN
    , .seed_i(seed_i)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_start();
`ifdef ADLER32_SEED_EN
    m_a = seed_i[15:0];
    m_b = seed_i[31:16];
    if (m_a >= MOD) m_a = m_a - MOD;
    if (m_b >= MOD) m_b = m_b - MOD;
`else
    m_a = 1;
    m_b = 0;
`endif
    m_busy = 1;
  endtask

  task automatic model_bytes(input logic [31:0] d, input int n);
    logic [7:0] bt;
    for (int k = 0; k < n; k++) begin
      bt  = d[31-8*k -: 8];
      m_a = (m_a + bt) % MOD;
      m_b = (m_b + m_a) % MOD;
    end
    m_dat = {m_b[15:0], m_a[15:0]};
  endtask

  // Drive one cycle, let the DUT take it, then check every output.
  task automatic drive(input bit st, input bit v, input logic [31:0] d,
                       input logic [1:0] n, input bit l);
    bit acc;
    start_i = st; val_i = v; dat_i = d; num_i = n; lst_i = l;
    acc = m_busy && v && !st;
    @(posedge clk);
    #1;
    if (st) begin
      model_start();
    end else if (acc) begin
      model_bytes(d, (n == 0) ? DB : int'(n));
      if (l) m_busy = 0;
    end
    chk("val_o", 32'(val_o), 32'(acc));
    chk("done_o", 32'(done_o), 32'(acc && l));
    chk("dat_o", dat_o, m_dat);
    chk("rdy_o", 32'(rdy_o), 32'(m_busy));
    start_i = 0; val_i = 0; lst_i = 0;
  endtask

  task automatic do_reset();
    rstn = 0;
    start_i = 0; val_i = 0; lst_i = 0; dat_i = '0; num_i = '0;
    @(posedge clk);
    #1;
    chk("rst_rdy", 32'(rdy_o), 32'd0);
    chk("rst_val", 32'(val_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    rstn = 1;
    m_busy = 0;
    m_dat = '0;
  endtask

  initial begin
    int nb;
    logic [31:0] r;
`ifdef ADLER32_SEED_EN
    seed_i = 32'h0000_0001;
`endif
    m_busy = 0; m_a = 1; m_b = 0; m_dat = '0;
    do_reset();

    // Beats offered while idle must be ignored.
    drive(0, 1, 32'h1234_5678, 2'd0, 1);

    // "Wikipedia" in three beats.
    drive(1, 0, '0, 2'd0, 0);
    drive(0, 1, 32'h5769_6B69, 2'd0, 0);
    drive(0, 1, 32'h7065_6469, 2'd0, 0);
    drive(0, 1, 32'h6100_0000, 2'd1, 1);
    chk("wiki_final", dat_o, 32'h11E6_0398);

    // "abc" in a single short beat, trailing byte must be ignored.
    drive(1, 0, '0, 2'd0, 0);
    drive(0, 1, 32'h6162_63FF, 2'd3, 1);
    chk("abc", dat_o, 32'h024D_0127);

    // Empty stream: single zero byte.
    drive(1, 0, '0, 2'd0, 0);
    drive(0, 1, 32'h0000_0000, 2'd1, 1);
    chk("empty", dat_o, 32'h0001_0001);

    // Long all-ones run exercising modulo wrap.
    drive(1, 0, '0, 2'd0, 0);
    for (int i = 0; i < 1024; i++) drive(0, 1, 32'hFFFF_FFFF, 2'd0, (i == 1023));

    // Reset in the middle of a stream, then a clean "abc".
    drive(1, 0, '0, 2'd0, 0);
    drive(0, 1, 32'hDEAD_BEEF, 2'd0, 0);
    do_reset();
    drive(1, 0, '0, 2'd0, 0);
    drive(0, 1, 32'h6162_6300, 2'd3, 1);
    chk("abc_after_rst", dat_o, 32'h024D_0127);

    // Restart colliding with a beat: beat dropped, sums re-initialised.
    drive(1, 0, '0, 2'd0, 0);
    drive(0, 1, 32'hAAAA_5555, 2'd0, 0);
    drive(1, 1, 32'h0102_0304, 2'd0, 0);
    drive(0, 1, 32'h6162_6300, 2'd3, 1);
    chk("abc_after_restart", dat_o, 32'h024D_0127);

    // Random streams with gaps, idle noise and lst_i without val_i.
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 3) == 0)
        drive(0, 1, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      drive(1, 0, '0, 2'd0, 0);
      nb = $urandom_range(1, 8);
      for (int b = 0; b < nb; b++) begin
        while ($urandom_range(0, 2) == 0)
          drive(0, 0, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        r = $urandom;
        drive(0, 1, r, (b == nb - 1) ? 2'($urandom_range(0, 3)) : 2'd0, (b == nb - 1));
      end
    end

`ifdef ADLER32_SEED_EN
    seed_i = 32'h024D_0127;
    drive(1, 0, '0, 2'd0, 0);
    drive(0, 1, 32'h6465_6600, 2'd3, 1);
    chk("seed_abcdef", dat_o, 32'h081E_0256);
    seed_i = 32'hFFF5_FFF2;
    drive(1, 0, '0, 2'd0, 0);
    drive(0, 1, $urandom, 2'd0, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
